// File: rtl/core_hlink_rx.sv
// core_hlink_rx: receive stage behind the core-to-core link buffer.
// Every beat on hlink_rdata/hlink_rvalid is captured into a small FIFO
// (the link has no backpressure) and handed to the local activation
// consumer over a valid/ready handshake. Each beat can also be relaunched
// toward the next core's link write port so activations daisy-chain.
//
// Handshake: a beat moves from the FIFO to the consumer in a cycle where
// act_rvalid and act_rready are both high; act_rvalid never depends on
// act_rready, and act_rdata is stable while act_rvalid is high and no pop
// occurs. act_rready while empty is ignored.

`ifndef MAC_MULT_NUM
`define MAC_MULT_NUM 4
`endif
`ifndef IDATA_WIDTH
`define IDATA_WIDTH 8
`endif

module core_hlink_rx #(
    parameter int CACHE_DATA_WIDTH = (`MAC_MULT_NUM * `IDATA_WIDTH),
    parameter int FIFO_DEPTH       = 4,
    parameter int CNT_WIDTH        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [CACHE_DATA_WIDTH-1:0] hlink_rdata,
    input  logic                        hlink_rvalid,
    input  logic                        fwd_en,
    output logic [CACHE_DATA_WIDTH-1:0] fwd_wdata,
    output logic                        fwd_wen,
    output logic [CACHE_DATA_WIDTH-1:0] act_rdata,
    output logic                        act_rvalid,
    input  logic                        act_rready,
    output logic [CNT_WIDTH-1:0]        fifo_count,
    output logic                        overflow,
    input  logic                        clr_overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0]     L_PTR_ONE = PTR_W'(1);
    localparam logic [CNT_WIDTH-1:0] L_CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] L_FULL    = CNT_WIDTH'(FIFO_DEPTH);

    // storage and bookkeeping
    logic [CACHE_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]            r_wr_ptr;
    logic [PTR_W-1:0]            r_rd_ptr;
    logic [CNT_WIDTH-1:0]        r_count;
    logic                        r_overflow;
    logic                        r_fwd_wen;
    logic [CACHE_DATA_WIDTH-1:0] r_fwd_wdata;

    // per-cycle decisions
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_fwd;

    // Push/pop/drop decode. A full FIFO still accepts a beat when the head
    // leaves in the same cycle, so only full-without-pop drops a beat.
    always_comb begin
        w_full  = (r_count == L_FULL);
        w_empty = (r_count == '0);
        w_pop   = !w_empty && act_rready;
        w_push  = hlink_rvalid && (!w_full || w_pop);
        w_drop  = hlink_rvalid && w_full && !w_pop;
        w_fwd   = hlink_rvalid && fwd_en;
    end

    // Storage write; entries clear on reset so act_rdata reads 0 then.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= hlink_rdata;
        end
    end

    // Write pointer, natural power-of-two wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
        end
    end

    // Read pointer, natural power-of-two wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
        end
    end

    // Occupancy: unchanged when push and pop coincide.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + L_CNT_ONE;
        end else if (w_pop && !w_push) begin
            r_count <= r_count - L_CNT_ONE;
        end
    end

    // Sticky drop flag; a drop in the clearing cycle keeps it set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    // Forward path to the next core, registered and blind to FIFO state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fwd_wen   <= 1'b0;
            r_fwd_wdata <= '0;
        end else begin
            r_fwd_wen <= w_fwd;
            if (w_fwd) begin
                r_fwd_wdata <= hlink_rdata;
            end
        end
    end

    // Output mapping; the head is read straight out of storage.
    always_comb begin
        act_rdata  = r_mem[r_rd_ptr];
        act_rvalid = !w_empty;
        fifo_count = r_count;
        overflow   = r_overflow;
        fwd_wen    = r_fwd_wen;
        fwd_wdata  = r_fwd_wdata;
    end

endmodule
